video_row_fetcher: RTL
======================

// Module: video_row_fetcher
// PURPOSE
//  SDRAM read side of the character-cell memory that the terminal stream writes.
//  On request, fetches one on-screen text row (COLUMNS 32-bit cells) by burst read.
//  Applies the scroll offset from VIDEO_SET_FIRST_ROW and stores the row in a
//  double-banked line buffer. The pixel pipeline reads that buffer while the next row fills.
// PARAMETERS
//  COLUMNS  80  cells per text row; also the burst length issued
//  ROWS     51  text rows in the ring; physical rows wrap modulo ROWS
// PORTS
//  clk              in   1   system clock; single clock domain
//  reset_n          in   1   asynchronous, active-low reset
//  register_index   in   4   video register bus from the terminal stream
//  register_value   in   23  register payload; VIDEO_SET_FIRST_ROW carries row<<9
//  line_request     in   1   1-cycle pulse: fetch line_row into line_bank
//  line_row         in   6   on-screen row, 0..ROWS-1
//  line_bank        in   1   destination buffer bank
//  line_ready       out  1   1-cycle pulse: fetch complete
//  line_overrun     out  1   1-cycle pulse: request arrived while busy and was dropped
//  line_error       out  1   1-cycle pulse: line_row >= ROWS and was dropped
//  busy             out  1   high from accepted request until line_ready
//  rd_address       out  23  SDRAM byte address, {8'b0,row[5:0],7'b0,2'b00}
//  rd_request       out  1   1-cycle request pulse
//  rd_burst_length  out  9   words requested; always COLUMNS
//  rd_data          in   32  returned cell
//  rd_data_valid    in   1   rd_data is valid this cycle
//  rd_done          in   1   1-cycle pulse: burst finished
//  pix_bank         in   1   read bank for the pixel pipeline
//  pix_x            in   7   column to read
//  pix_data         out  32  cell at {pix_bank,pix_x}; registered, 1-cycle latency
// BEHAVIOUR
//  Reset (async, reset_n low):
//  - first_row=0; state IDLE.
//  - All outputs 0, except rd_burst_length=COLUMNS.
//  - Line buffer contents are undefined.
//  Register bus:
//  - When register_index==VIDEO_SET_FIRST_ROW, first_row <= register_value[14:9]
//    on the next edge. Updates are accepted in every state.
//  - The fetch in flight uses the first_row value latched at request acceptance.
//  - All other register indices are ignored.
//  Address arithmetic (7-bit sum):
//  - phys = line_row + first_row; if phys >= ROWS then phys -= ROWS.
//  - rd_address = {8'b0,phys,7'b0,2'b00}.
//  FSM:
//  - IDLE:
//    - line_request with line_row < ROWS: latch bank, compute address, clear word
//      counter wc, busy=1, go to REQUEST.
//    - line_row >= ROWS: pulse line_error and stay in IDLE.
//  - REQUEST: rd_request=1 for exactly one cycle, then go to RECEIVE.
//  - RECEIVE:
//    - On each rd_data_valid with wc < COLUMNS: write rd_data to buffer[{bank,wc}],
//      then wc++.
//    - Valid words with wc >= COLUMNS are discarded.
//    - On rd_done: go to DONE. If data_valid and done coincide, the word is stored first.
//    - A short burst (done before COLUMNS words) leaves the remaining entries unchanged.
//  - DONE: line_ready=1 for one cycle, busy=0, go to IDLE.
//    - Latency from request to line_ready is rd_done arrival + 1 cycle.
//  - A line_request in any state other than IDLE pulses line_overrun. The request is
//    not queued and the fetch in flight is unaffected.
//  Pixel read port:
//  - Independent of the FSM.
//  - Reading the bank currently being filled returns old or new data per cell; no hazard logic.
//  - Reset mid-fetch aborts the fetch immediately: rd_request drops the same instant.
//    SDRAM beats still arriving after reset release are ignored in IDLE.
// STRUCTURE
//  - Shared includes:
//    - COLUMNS, ROWS, ROW_SIZE from constant.v.
//    - VIDEO_SET_FIRST_ROW from video_controller/registers.v.
//    - The row-address function is shared with the writer.
//  - Sub-module line_buffer: simple dual-port RAM, 256x32.
//    - Write port: FSM, address {bank,wc[6:0]}.
//    - Read port: pixel, registered output.
//  - Top level: FSM, word counter, first_row register, address adder.
// TESTING
//  1. first_row=0; request row 0 bank 0; 80 beats of data i -> rd_address=0,
//     burst=80, buffer[0][i]=i, line_ready 1 cycle after rd_done.
//  2. Write first_row via VIDEO_SET_FIRST_ROW value 0x6400 (row 50).
//     - Request row 0 -> rd_address=0x6400.
//     - Request row 1 -> wraps, rd_address=0.
//  3. Second line_request 5 cycles into RECEIVE -> line_overrun pulse; first fetch
//     completes normally; one rd_request total.
//  4. rd_done after 40 beats into bank 1, preloaded with 0xFFFFFFFF -> line_ready;
//     entries 40..79 still 0xFFFFFFFF.
//  5. reset_n low mid-RECEIVE, then release -> rd_request/busy 0 at once; the next
//     request fetches normally.
//  6. Request row 51 -> line_error pulse, no rd_request, busy stays 0. Then 90 beats
//     on a valid request -> only 80 stored.

Source files
------------

// File: rtl/video_row_fetcher_pkg.sv
// ----------------------------------------------------------------------------
// video_row_fetcher_pkg
//   Shared constants and helpers for the SDRAM character-cell row fetcher:
//   screen geometry, the video register index that moves the scroll origin,
//   the fetch FSM state type and the row-to-SDRAM address mapping that the
//   terminal writer uses as well.
// ----------------------------------------------------------------------------
package video_row_fetcher_pkg;

    // Screen geometry: cells per text row (also the burst length) and rows in
    // the circular character store.
    localparam int COLUMNS  = 80;
    localparam int ROWS     = 51;

    // Bytes reserved per row in SDRAM: 128 cells of 4 bytes, so a row starts
    // on a 512-byte boundary even though only COLUMNS cells are used.
    localparam int ROW_SIZE = 512;

    // Video register bus index that carries the scroll origin as row<<9.
    localparam logic [3:0] VIDEO_SET_FIRST_ROW = 4'd5;

    // Line buffer geometry: two banks of 128 cells.
    localparam int BUF_AW = 8;
    localparam int BUF_DW = 32;

    typedef enum logic [1:0] {
        FETCH_IDLE,
        FETCH_REQUEST,
        FETCH_RECEIVE,
        FETCH_DONE
    } fetch_state_t;

    // SDRAM byte address of a physical row: {8'b0, row[5:0], 7'b0, 2'b00}.
    function automatic logic [22:0] row_address(input logic [5:0] row);
        return 23'(row) << $clog2(ROW_SIZE);
    endfunction

endpackage

// File: rtl/video_row_fetcher_line_buffer.sv
// ----------------------------------------------------------------------------
// video_row_fetcher_line_buffer
//   Simple dual-port 256x32 RAM holding two banks of one text row each.
//   The fetch FSM writes through the write port while the pixel pipeline
//   reads through the registered read port; there is no collision logic, a
//   read of a cell being written returns either the old or the new value.
// Ports
//   clk            in   1    system clock
//   reset_n        in   1    async active-low reset (clears read_data only)
//   write_enable   in   1    store write_data at write_address
//   write_address  in   8    {bank, column}
//   write_data     in   32   cell value
//   read_address   in   8    {bank, column}
//   read_data      out  32   cell at read_address, one cycle later
// ----------------------------------------------------------------------------
module video_row_fetcher_line_buffer
    import video_row_fetcher_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              write_enable,
    input  logic [BUF_AW-1:0] write_address,
    input  logic [BUF_DW-1:0] write_data,
    input  logic [BUF_AW-1:0] read_address,
    output logic [BUF_DW-1:0] read_data
);

    logic [BUF_DW-1:0] mem [2**BUF_AW];

    // NOTE: the array has no reset so it maps onto block RAM; its contents
    // after reset are undefined and nobody relies on them.
    always_ff @(posedge clk) begin
        if (write_enable) begin
            mem[write_address] <= write_data;
        end
    end

    // The output register does reset, so pix_data reads 0 after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            read_data <= '0;
        end else begin
            read_data <= mem[read_address];
        end
    end

endmodule

// File: rtl/video_row_fetcher.sv
// ----------------------------------------------------------------------------
// video_row_fetcher
//   SDRAM read side of the character-cell store. On line_request it fetches one
//   on-screen text row (COLUMNS cells) with a single burst, translating the
//   on-screen row to a physical ring row with the scroll origin, and writes the
//   cells into one bank of a double-banked line buffer. The pixel pipeline
//   reads the other bank (or any bank) through a registered read port.
// Ports
//   clk, reset_n                 clock, async active-low reset
//   register_index/value  in     video register bus; VIDEO_SET_FIRST_ROW
//                                moves the scroll origin (value = row<<9)
//   line_request          in     1-cycle pulse: fetch line_row into line_bank
//   line_row, line_bank   in     on-screen row (0..ROWS-1), destination bank
//   line_ready            out    1-cycle pulse: row stored
//   line_overrun          out    1-cycle pulse: request dropped while busy
//   line_error            out    1-cycle pulse: request dropped, row >= ROWS
//   busy                  out    accepted request not yet completed
//   rd_address            out    SDRAM byte address of the burst
//   rd_request            out    1-cycle burst request
//   rd_burst_length       out    always COLUMNS
//   rd_data, rd_data_valid, rd_done   in   returned burst beats
//   pix_bank, pix_x       in     pixel pipeline read address
//   pix_data              out    cell at {pix_bank,pix_x}, 1-cycle latency
// ----------------------------------------------------------------------------
module video_row_fetcher
    import video_row_fetcher_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  register_index,
    input  logic [22:0] register_value,
    input  logic        line_request,
    input  logic [5:0]  line_row,
    input  logic        line_bank,
    output logic        line_ready,
    output logic        line_overrun,
    output logic        line_error,
    output logic        busy,
    output logic [22:0] rd_address,
    output logic        rd_request,
    output logic [8:0]  rd_burst_length,
    input  logic [31:0] rd_data,
    input  logic        rd_data_valid,
    input  logic        rd_done,
    input  logic        pix_bank,
    input  logic [6:0]  pix_x,
    output logic [31:0] pix_data
);

    localparam logic [6:0] ROWS_7    = 7'(ROWS);
    localparam logic [6:0] COLUMNS_7 = 7'(COLUMNS);

    fetch_state_t state;
    logic [5:0]   first_row;
    logic         bank;
    logic [6:0]   wc;
    logic [6:0]   row_sum;
    logic [5:0]   phys_row;
    logic         row_ok;
    logic         buf_we;

    // Only row bits of the register payload are meaningful here.
    logic unused_register_bits;
    assign unused_register_bits = ^{register_value[22:15], register_value[8:0]};

    assign rd_burst_length = 9'(COLUMNS);

    // ------------------------------------------------------------------
    // Scroll origin. Writes are taken in every state; a fetch in flight is
    // unaffected because its address was captured when it was accepted.
    // ------------------------------------------------------------------
    // NOTE: sequential state is assigned with non-blocking (<=) so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            first_row <= '0;
        end else if (register_index == VIDEO_SET_FIRST_ROW) begin
            first_row <= register_value[14:9];
        end
    end

    // ------------------------------------------------------------------
    // On-screen to physical row: 7-bit sum, one conditional subtract.
    // Inputs are below ROWS whenever the result is used, so one subtract
    // always lands back in range.
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets an unconditional value before any branch,
        // so no path can hold a stale value and infer a latch.
        row_sum  = {1'b0, line_row} + {1'b0, first_row};
        phys_row = row_sum[5:0];
        if (row_sum >= ROWS_7) begin
            phys_row = 6'(row_sum - ROWS_7);
        end
    end

    assign row_ok = ({1'b0, line_row} < ROWS_7);

    // Words past COLUMNS in an over-long burst are dropped; wc saturates.
    assign buf_we = (state == FETCH_RECEIVE) && rd_data_valid && (wc < COLUMNS_7);

    // ------------------------------------------------------------------
    // Fetch FSM with registered outputs. Reset clears rd_request and busy
    // asynchronously, which is what aborts a fetch in flight.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= FETCH_IDLE;
            bank         <= 1'b0;
            wc           <= '0;
            busy         <= 1'b0;
            rd_request   <= 1'b0;
            rd_address   <= '0;
            line_ready   <= 1'b0;
            line_overrun <= 1'b0;
            line_error   <= 1'b0;
        end else begin
            rd_request   <= 1'b0;
            line_ready   <= 1'b0;
            line_overrun <= 1'b0;
            line_error   <= 1'b0;

            // Requests outside IDLE are dropped, never queued.
            if (line_request && (state != FETCH_IDLE)) begin
                line_overrun <= 1'b1;
            end

            case (state)
                FETCH_IDLE: begin
                    if (line_request) begin
                        if (row_ok) begin
                            bank       <= line_bank;
                            rd_address <= row_address(phys_row);
                            wc         <= '0;
                            busy       <= 1'b1;
                            rd_request <= 1'b1;
                            state      <= FETCH_REQUEST;
                        end else begin
                            line_error <= 1'b1;
                        end
                    end
                end

                // rd_request is high for exactly this one cycle.
                FETCH_REQUEST: begin
                    state <= FETCH_RECEIVE;
                end

                // A beat coinciding with rd_done is stored before finishing.
                FETCH_RECEIVE: begin
                    if (buf_we) begin
                        wc <= wc + 7'd1;
                    end
                    if (rd_done) begin
                        line_ready <= 1'b1;
                        busy       <= 1'b0;
                        state      <= FETCH_DONE;
                    end
                end

                FETCH_DONE: begin
                    state <= FETCH_IDLE;
                end

                default: begin
                    state <= FETCH_IDLE;
                end
            endcase
        end
    end

    video_row_fetcher_line_buffer u_line_buffer (
        .clk           (clk),
        .reset_n       (reset_n),
        .write_enable  (buf_we),
        .write_address ({bank, wc}),
        .write_data    (rd_data),
        .read_address  ({pix_bank, pix_x}),
        .read_data     (pix_data)
    );

endmodule
